// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, field layouts, exception codes and
// the packing helpers used by both the CP0 unit and the decode stage.
package cp0_pkg;

    localparam logic [4:0] CP0_ADDR_SR    = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC   = 5'd14;
    localparam logic [4:0] CP0_ADDR_PRID  = 5'd15;

    localparam int SR_IE_BIT      = 0;
    localparam int SR_EXL_BIT     = 1;
    localparam int SR_IM_LSB      = 10;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_IP_LSB   = 10;
    localparam int CAUSE_BD_BIT   = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT      = 32'h2024_0001;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } cp0_sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cp0_cause_t;

    function automatic logic [31:0] pack_sr(input cp0_sr_t sr);
        logic [31:0] v;
        v = 32'h0;
        v[SR_IM_LSB +: 6] = sr.im;
        v[SR_EXL_BIT]     = sr.exl;
        v[SR_IE_BIT]      = sr.ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input cp0_cause_t c);
        logic [31:0] v;
        v = 32'h0;
        v[CAUSE_BD_BIT]        = c.bd;
        v[CAUSE_IP_LSB +: 6]   = c.ip;
        v[CAUSE_EXC_LSB +: 5]  = c.exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_unit_int_arb.sv
// Interrupt/exception request arbitration; interrupts win over synchronous
// exceptions and nothing is requested while EXL is set.
module cp0_int_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  cp0_sr_t    sr,
    input  logic [4:0] exc_code,
    output logic       int_req,
    output logic       req,
    output logic [4:0] exc_code_sel
);

    logic exc_req;

    always_comb begin
        int_req      = (|(hw_int & sr.im)) & sr.ie & ~sr.exl;
        exc_req      = (exc_code != 5'd0) & ~sr.exl;
        req          = int_req | exc_req;
        exc_code_sel = int_req ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) with exception entry,
// eret handling and mtc0/mfc0 access.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT,
    parameter logic [31:0] PRID_VAL  = PRID_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] entry_pc
);

    cp0_sr_t     sr_q, sr_d;
    cp0_cause_t  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic [4:0]  exc_code_sel;
    logic [31:0] victim_pc;
    logic        wr_sr, wr_epc;

    cp0_int_arb u_arb (
        .hw_int       (hw_int),
        .sr           (sr_q),
        .exc_code     (exc_code),
        .int_req      (int_req),
        .req          (req),
        .exc_code_sel (exc_code_sel)
    );

    always_comb begin
        // Exception entry owns the registers this cycle; mtc0 and eret are dropped.
        wr_sr     = en & ~req & (cp0_addr == CP0_ADDR_SR);
        wr_epc    = en & ~req & (cp0_addr == CP0_ADDR_EPC);
        victim_pc = bd_in ? (vpc - 32'd4) : vpc;

        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;

        cause_d.ip = hw_int;

        if (req) begin
            sr_d.exl    = 1'b1;
            cause_d.bd  = bd_in;
            cause_d.exc = exc_code_sel;
            epc_d       = {victim_pc[31:2], 2'b00};
        end else begin
            if (wr_sr) begin
                sr_d.im  = cp0_wdata[SR_IM_LSB +: 6];
                sr_d.exl = cp0_wdata[SR_EXL_BIT];
                sr_d.ie  = cp0_wdata[SR_IE_BIT];
            end
            // eret wins over the EXL bit of a simultaneous SR write.
            if (eret) begin
                sr_d.exl = 1'b0;
            end
            if (wr_epc) begin
                epc_d = cp0_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        case (cp0_addr)
            CP0_ADDR_SR:    cp0_rdata = pack_sr(sr_q);
            CP0_ADDR_CAUSE: cp0_rdata = pack_cause(cause_q);
            CP0_ADDR_EPC:   cp0_rdata = epc_q;
            CP0_ADDR_PRID:  cp0_rdata = PRID_VAL;
            default:        cp0_rdata = 32'h0;
        endcase
    end

    assign epc_out  = epc_q;
    assign entry_pc = EXC_ENTRY;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: a sequential vector table plus hand-written
// reset and read-timing sequences.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code;
    logic        eret;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] entry_pc;

    int checks = 0;
    int errors = 0;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .vpc       (vpc),
        .bd_in     (bd_in),
        .exc_code  (exc_code),
        .eret      (eret),
        .hw_int    (hw_int),
        .req       (req),
        .epc_out   (epc_out),
        .entry_pc  (entry_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic        eret;
        logic [5:0]  hw;
        logic        exp_req;
        logic [4:0]  chk_addr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en        = 1'b0;
        cp0_wdata = 32'h0;
        vpc       = 32'h0;
        bd_in     = 1'b0;
        exc_code  = 5'd0;
        eret      = 1'b0;
    endtask

    task automatic add(input string name, input logic e, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input logic bd, input logic [4:0] ex, input logic er,
                       input logic [5:0] hw, input logic xr, input logic [4:0] ca,
                       input logic [31:0] xd, input logic [31:0] xe);
        vec_t v;
        v.name = name; v.en = e; v.addr = a; v.wdata = wd; v.vpc = pc; v.bd = bd;
        v.exc = ex; v.eret = er; v.hw = hw; v.exp_req = xr; v.chk_addr = ca;
        v.exp_rdata = xd; v.exp_epc = xe;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        en = v.en; cp0_addr = v.addr; cp0_wdata = v.wdata; vpc = v.vpc;
        bd_in = v.bd; exc_code = v.exc; eret = v.eret; hw_int = v.hw;
        #1;
        check32({v.name, "_req"}, {31'h0, req}, {31'h0, v.exp_req});
        @(posedge clk);
        #1;
        idle_inputs();
        cp0_addr = v.chk_addr;
        #1;
        check32({v.name, "_rdata"}, cp0_rdata, v.exp_rdata);
        check32({v.name, "_epc"}, epc_out, v.exp_epc);
    endtask

    initial begin
        reset    = 1'b1;
        idle_inputs();
        hw_int   = 6'h0;
        cp0_addr = 5'd0;

        //   name        en addr wdata          vpc            bd exc    eret hw        req chk  exp_rdata      exp_epc
        add("sr_wr",     1, 12, 32'h0000_FC01, 32'h0,         0, 5'd0,  0, 6'b000000, 0, 12, 32'h0000_FC01, 32'h0);
        add("int_take",  0, 12, 32'h0,         32'h0000_2000, 0, 5'd0,  0, 6'b000100, 1, 13, 32'h0000_1000, 32'h0000_2000);
        add("exl_set",   0, 12, 32'h0,         32'h0,         0, 5'd0,  0, 6'b000100, 0, 12, 32'h0000_FC03, 32'h0000_2000);
        add("eret1",     0, 0,  32'h0,         32'h0,         0, 5'd0,  1, 6'b000000, 0, 12, 32'h0000_FC01, 32'h0000_2000);
        add("exc_bd",    0, 0,  32'h0,         32'h0000_3010, 1, 5'd4,  0, 6'b000000, 1, 13, 32'h8000_0010, 32'h0000_300C);
        add("exl_block", 0, 0,  32'h0,         32'h0000_5000, 0, 5'd10, 0, 6'b000000, 0, 13, 32'h8000_0010, 32'h0000_300C);
        add("ip_in_exl", 0, 0,  32'h0,         32'h0,         0, 5'd0,  0, 6'b000001, 0, 13, 32'h8000_0410, 32'h0000_300C);
        add("eret2",     0, 0,  32'h0,         32'h0,         0, 5'd0,  1, 6'b000000, 0, 12, 32'h0000_FC01, 32'h0000_300C);
        add("wr_drop",   1, 14, 32'h0000_1234, 32'h0000_4444, 0, 5'd12, 0, 6'b000000, 1, 14, 32'h0000_4444, 32'h0000_4444);
        add("eret_sr",   1, 12, 32'h0000_0403, 32'h0,         0, 5'd0,  1, 6'b000000, 0, 12, 32'h0000_0401, 32'h0000_4444);
        add("int_wins",  0, 0,  32'h0,         32'h0000_6003, 0, 5'd8,  0, 6'b000001, 1, 13, 32'h0000_0400, 32'h0000_6000);
        add("eret3",     0, 0,  32'h0,         32'h0,         0, 5'd0,  1, 6'b000000, 0, 12, 32'h0000_0401, 32'h0000_6000);
        add("eret_req",  0, 0,  32'h0,         32'h0,         1, 5'd2,  1, 6'b000000, 1, 12, 32'h0000_0403, 32'hFFFF_FFFC);
        add("cause_ro",  1, 13, 32'hFFFF_FFFF, 32'h0,         0, 5'd0,  0, 6'b000000, 0, 13, 32'h8000_0008, 32'hFFFF_FFFC);
        add("epc_wr",    1, 14, 32'h0000_1237, 32'h0,         0, 5'd0,  0, 6'b000000, 0, 14, 32'h0000_1237, 32'h0000_1237);
        add("sr_mask",   1, 12, 32'hFFFF_FFFF, 32'h0,         0, 5'd0,  0, 6'b000000, 0, 12, 32'h0000_FC03, 32'h0000_1237);
        add("prid_ro",   1, 15, 32'h0,         32'h0,         0, 5'd0,  0, 6'b000000, 0, 15, 32'h2024_0001, 32'h0000_1237);
        add("unmapped",  1, 7,  32'hFFFF_FFFF, 32'h0,         0, 5'd0,  0, 6'b000000, 0, 7,  32'h0,         32'h0000_1237);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        cp0_addr = 5'd12; #1; check32("rst_sr", cp0_rdata, 32'h0);
        cp0_addr = 5'd13; #1; check32("rst_cause", cp0_rdata, 32'h0);
        cp0_addr = 5'd14; #1; check32("rst_epc", cp0_rdata, 32'h0);
        cp0_addr = 5'd15; #1; check32("rst_prid", cp0_rdata, 32'h2024_0001);
        cp0_addr = 5'd3;  #1; check32("rst_unmapped", cp0_rdata, 32'h0);
        check32("rst_req", {31'h0, req}, 32'h0);
        check32("entry_pc", entry_pc, 32'h0000_4180);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Asynchronous reset mid-cycle with EXL=1 clears state before the next edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        cp0_addr = 5'd12; #0.5; check32("mid_rst_sr", cp0_rdata, 32'h0);
        cp0_addr = 5'd13; #0.5; check32("mid_rst_cause", cp0_rdata, 32'h0);
        cp0_addr = 5'd14; #0.5; check32("mid_rst_epc", cp0_rdata, 32'h0);
        cp0_addr = 5'd15; #0.5; check32("mid_rst_prid", cp0_rdata, 32'h2024_0001);
        hw_int = 6'b111111; #0.5;
        check32("mid_rst_req", {31'h0, req}, 32'h0);
        check32("mid_rst_entry", entry_pc, 32'h0000_4180);
        @(negedge clk);
        reset  = 1'b0;
        hw_int = 6'b000000;

        // First edge after reset takes an exception normally.
        exc_code = 5'd3; vpc = 32'h0000_0100; bd_in = 1'b0;
        #1;
        check32("post_rst_req", {31'h0, req}, 32'h1);
        @(posedge clk);
        #1;
        idle_inputs();
        cp0_addr = 5'd12; #1; check32("post_rst_sr", cp0_rdata, 32'h0000_0002);
        check32("post_rst_epc", epc_out, 32'h0000_0100);

        // mtc0 to EPC: read shows old value until the edge.
        @(negedge clk);
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_ABCD;
        #1;
        check32("nobypass_pre", cp0_rdata, 32'h0000_0100);
        @(posedge clk);
        #1;
        en = 1'b0;
        #1;
        check32("nobypass_post", cp0_rdata, 32'h0000_ABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within 20000 time units");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
